pulse_sequencer: RTL
====================

PULSE_SEQUENCER -- requirements
Module: pulse_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  CHANNELS  24  digital output channel count
  ADDR_W  15  instruction memory address width
  DATA_W  20  opcode data field width
  TIME_W  32  duration field width
  LOOP_DEPTH  4  nested-loop stack depth (1..8)
REQ-002 Ports (name  direction  width  meaning), one per line:
  clk  in  1  sole clock; all logic on rising edge
  reset  in  1  synchronous, active-high reset
  start  in  1  level; sampled in IDLE/DONE to launch program at address 0
  abort  in  1  level; stops sequencing
  trigger  in  1  external trigger, synchronous to clk
  instr_word  in  CHANNELS+4+DATA_W+TIME_W  {flags, opcode[3:0], data, time_arg}, valid one cycle after mem_addr
  mem_addr  out  ADDR_W  instruction address (registered)
  channels  out  CHANNELS  registered channel outputs
  busy  out  1  high in any state except IDLE, DONE, ERROR
  done  out  1  high in DONE
  error  out  1  high in ERROR
  loop_level  out  4  current loop stack occupancy

Function
REQ-003 States SHALL be IDLE, FETCH, DECODE, HOLD, WAIT_TRIG, DONE, ERROR.
REQ-004 IDLE or DONE with start=1 SHALL set mem_addr=0, clear the loop stack, and enter FETCH; FETCH SHALL always go to DECODE next cycle.
REQ-005 In DECODE, fields SHALL be taken from instr_word; opcodes: 0 CONT, 1 STOP, 2 LOOP_START, 3 LOOP_END, 4 WAIT_TRIG, 5 JUMP; 6-15 SHALL execute as CONT.
REQ-006 Output opcodes (CONT, STOP, WAIT_TRIG) SHALL load channels=flags, visible the cycle after DECODE.
REQ-007 Word duration T = max(time_arg,2): channels SHALL hold flags exactly T cycles before the next output word's flags appear, given no intervening control words; HOLD SHALL last T-2 cycles, then FETCH of mem_addr+1.
REQ-008 STOP SHALL hold flags T cycles, then enter DONE with channels unchanged; done=1 from cycle D+T+1, where D = STOP decode cycle.
REQ-009 WAIT_TRIG SHALL load flags, then remain in WAIT_TRIG until a trigger rising edge (trigger=1, previous sample 0); the T-cycle duration SHALL count from the edge cycle. A trigger already high on entry SHALL NOT count.
REQ-010 Control opcodes (LOOP_START, LOOP_END, JUMP) SHALL leave channels unchanged and cost exactly 2 cycles (FETCH+DECODE); those cycles extend the preceding output word.
REQ-011 LOOP_START SHALL push {ret=mem_addr+1, count=data}; data=0 SHALL be treated as 1.
REQ-012 LOOP_END SHALL, if top count>1, decrement it and jump to ret; otherwise pop and continue at mem_addr+1.
REQ-013 JUMP SHALL set next address = data[ADDR_W-1:0].
REQ-014 Push with LOOP_DEPTH entries, or LOOP_END with empty stack, SHALL enter ERROR: channels=0, error=1, held until reset; start and abort are ignored in ERROR.
REQ-015 mem_addr+1 SHALL wrap from 2^ADDR_W-1 to 0 without error.
REQ-016 Abort=1 in any busy state SHALL, next cycle, force IDLE, channels=0, and empty the stack; abort has priority over start and trigger.
REQ-017 Start SHALL be ignored while busy; start and abort both high in IDLE/DONE SHALL remain/enter IDLE.
REQ-018 Time counter SHALL be TIME_W bits; time_arg=2^TIME_W-1 SHALL hold exactly that many cycles without overflow.

Reset
REQ-019 Reset SHALL force IDLE, mem_addr=0, channels=0, busy=0, done=0, error=0, loop_level=0, and an empty stack; it overrides all inputs, including mid-program and in ERROR.

Verification
REQ-020 CONT flags=0x000001 T=5; STOP flags=0x000002 T=4; start high at cycle 0 -> channels=0x000001 cycles 3-7, 0x000002 cycles 8-11, done=1 from cycle 12.
REQ-021 LOOP_START data=3; CONT 0x1 T=4; CONT 0x0 T=4; LOOP_END; STOP 0x0 T=2 -> exactly 3 high pulses of 4 cycles, separated by 6 low cycles; loop_level 1 during the loop, 0 at DONE.
REQ-022 WAIT_TRIG flags=0xF T=3, trigger held high on entry, then a low-to-high edge at cycle N -> channels=0xF until cycle N+3, after which the next word's flags appear.
REQ-023 LOOP_DEPTH=2 with three nested LOOP_STARTs -> error=1, channels=0 the cycle after the third decode; start ignored until reset.
REQ-024 Abort during HOLD of a T=100 word -> IDLE next cycle, channels=0, busy=0; a later start restarts at address 0.
REQ-025 JUMP data=0x7FFF (ADDR_W=15), then CONT at 0x7FFF -> next fetch at address 0; T=0 and T=1 words each hold 2 cycles.

Source files
------------

// File: rtl/pulse_sequencer.sv
// Instruction-driven digital pulse sequencer: fetches words from external memory, drives channel
// flags for programmed durations, and supports nested loops, jumps and trigger waits.
module pulse_sequencer #(
    parameter int unsigned CHANNELS   = 24,
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned DATA_W     = 20,
    parameter int unsigned TIME_W     = 32,
    parameter int unsigned LOOP_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic                                 trigger,
    input  logic [CHANNELS+4+DATA_W+TIME_W-1:0]  instr_word,
    output logic [ADDR_W-1:0]                    mem_addr,
    output logic [CHANNELS-1:0]                  channels,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 error,
    output logic [3:0]                           loop_level
);

    localparam int unsigned IW    = CHANNELS + 4 + DATA_W + TIME_W;
    localparam logic [3:0]  Depth = 4'(LOOP_DEPTH);

    localparam logic [3:0] OpStop      = 4'd1;
    localparam logic [3:0] OpLoopStart = 4'd2;
    localparam logic [3:0] OpLoopEnd   = 4'd3;
    localparam logic [3:0] OpWaitTrig  = 4'd4;
    localparam logic [3:0] OpJump      = 4'd5;

    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StHold, StWaitTrig, StDone, StError
    } state_e;

    state_e              state_q;
    logic [TIME_W-1:0]   hold_cnt_q;
    logic [ADDR_W-1:0]   next_addr_q;
    logic                stop_q;
    logic                trig_prev_q;
    logic [3:0]          sp_q;
    logic [ADDR_W-1:0]   ret_q [8];
    logic [DATA_W-1:0]   cnt_q [8];

    logic [CHANNELS-1:0] flags;
    logic [3:0]          opcode;
    logic [DATA_W-1:0]   data;
    logic [TIME_W-1:0]   time_arg;
    logic [TIME_W-1:0]   dur;
    logic [DATA_W-1:0]   loop_cnt;
    logic [ADDR_W-1:0]   addr_inc;
    logic [2:0]          top;
    logic                trig_edge;

    assign flags     = instr_word[IW-1 -: CHANNELS];
    assign opcode    = instr_word[DATA_W+TIME_W +: 4];
    assign data      = instr_word[TIME_W +: DATA_W];
    assign time_arg  = instr_word[TIME_W-1:0];
    assign dur       = (time_arg < TIME_W'(2)) ? TIME_W'(2) : time_arg;
    assign loop_cnt  = (data == '0) ? DATA_W'(1) : data;
    assign addr_inc  = mem_addr + ADDR_W'(1);
    assign top       = 3'(sp_q - 4'd1);
    assign trig_edge = trigger && !trig_prev_q;

    assign busy       = (state_q != StIdle) && (state_q != StDone) && (state_q != StError);
    assign done       = (state_q == StDone);
    assign error      = (state_q == StError);
    assign loop_level = sp_q;

    always_ff @(posedge clk) begin
        trig_prev_q <= trigger;
        if (reset) begin
            state_q     <= StIdle;
            mem_addr    <= '0;
            channels    <= '0;
            sp_q        <= '0;
            hold_cnt_q  <= '0;
            next_addr_q <= '0;
            stop_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start && abort) begin
                        state_q  <= StIdle;
                        channels <= '0;
                    end else if (start) begin
                        state_q  <= StFetch;
                        mem_addr <= '0;
                        sp_q     <= '0;
                    end
                end
                StError: ;
                default: begin
                    if (abort) begin
                        state_q  <= StIdle;
                        channels <= '0;
                        sp_q     <= '0;
                    end else begin
                        case (state_q)
                            StFetch: state_q <= StDecode;
                            StDecode: begin
                                case (opcode)
                                    OpStop: begin
                                        // STOP holds the full T cycles in HOLD, no trailing fetch.
                                        channels   <= flags;
                                        stop_q     <= 1'b1;
                                        hold_cnt_q <= dur;
                                        state_q    <= StHold;
                                    end
                                    OpLoopStart: begin
                                        if (sp_q == Depth) begin
                                            state_q  <= StError;
                                            channels <= '0;
                                        end else begin
                                            ret_q[sp_q[2:0]] <= addr_inc;
                                            cnt_q[sp_q[2:0]] <= loop_cnt;
                                            sp_q             <= sp_q + 4'd1;
                                            mem_addr         <= addr_inc;
                                            state_q          <= StFetch;
                                        end
                                    end
                                    OpLoopEnd: begin
                                        if (sp_q == 4'd0) begin
                                            state_q  <= StError;
                                            channels <= '0;
                                        end else if (cnt_q[top] > DATA_W'(1)) begin
                                            cnt_q[top] <= cnt_q[top] - DATA_W'(1);
                                            mem_addr   <= ret_q[top];
                                            state_q    <= StFetch;
                                        end else begin
                                            sp_q     <= sp_q - 4'd1;
                                            mem_addr <= addr_inc;
                                            state_q  <= StFetch;
                                        end
                                    end
                                    OpJump: begin
                                        mem_addr <= data[ADDR_W-1:0];
                                        state_q  <= StFetch;
                                    end
                                    OpWaitTrig: begin
                                        // Prefetch now so a T=2 edge can go straight to DECODE.
                                        channels    <= flags;
                                        stop_q      <= 1'b0;
                                        mem_addr    <= addr_inc;
                                        next_addr_q <= addr_inc;
                                        hold_cnt_q  <= dur;
                                        state_q     <= StWaitTrig;
                                    end
                                    default: begin
                                        channels    <= flags;
                                        stop_q      <= 1'b0;
                                        next_addr_q <= addr_inc;
                                        if (dur == TIME_W'(2)) begin
                                            mem_addr <= addr_inc;
                                            state_q  <= StFetch;
                                        end else begin
                                            hold_cnt_q <= dur - TIME_W'(2);
                                            state_q    <= StHold;
                                        end
                                    end
                                endcase
                            end
                            StHold: begin
                                if (hold_cnt_q <= TIME_W'(1)) begin
                                    if (stop_q) begin
                                        state_q <= StDone;
                                    end else begin
                                        mem_addr <= next_addr_q;
                                        state_q  <= StFetch;
                                    end
                                end else begin
                                    hold_cnt_q <= hold_cnt_q - TIME_W'(1);
                                end
                            end
                            StWaitTrig: begin
                                // The edge cycle is the first of the word's T cycles.
                                if (trig_edge) begin
                                    if (hold_cnt_q == TIME_W'(2)) begin
                                        state_q <= StDecode;
                                    end else if (hold_cnt_q == TIME_W'(3)) begin
                                        state_q <= StFetch;
                                    end else begin
                                        hold_cnt_q <= hold_cnt_q - TIME_W'(3);
                                        state_q    <= StHold;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
